// File: rtl/int16_pipe_share_arbiter_pkg.sv
// Shared constants and FSM encoding for the INT16 shared-pipeline arbiter.
package int16_pipe_share_arbiter_pkg;

  localparam int N_REQ_DEF   = 4;
  localparam int WIDTH_DEF   = 16;
  localparam int LATENCY_DEF = 2;
  localparam int ID_W        = $clog2(N_REQ_DEF);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/int16_pipe_share_arbiter_if.sv
// Requester, shared-unit and drain-control signals of the arbiter, bundled.
interface int16_pipe_share_arbiter_if
  import int16_pipe_share_arbiter_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int WIDTH = WIDTH_DEF
);
  // Handshake: requester i transfers req_data slice i on a rising edge where
  // req_valid[i] && req_ready[i]; ready is derived from valid, so a requester
  // raises valid without waiting for ready. Responses (rsp_valid one-hot) have
  // no backpressure and must be taken in the cycle they appear.
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ*WIDTH-1:0] req_data;
  logic [N_REQ-1:0]       req_ready;
  logic [WIDTH-1:0]       unit_in;
  logic [WIDTH-1:0]       unit_out;
  logic [N_REQ-1:0]       rsp_valid;
  logic [WIDTH-1:0]       rsp_data;
  logic                   drain_req;
  logic                   drain_done;
  logic                   busy;
  state_e                 state_dbg;

  modport master (
    output req_valid, req_data, unit_out, drain_req,
    input  req_ready, unit_in, rsp_valid, rsp_data, drain_done, busy, state_dbg
  );

  modport slave (
    input  req_valid, req_data, unit_out, drain_req,
    output req_ready, unit_in, rsp_valid, rsp_data, drain_done, busy, state_dbg
  );
endinterface

// File: rtl/int16_pipe_tag_delay.sv
// LATENCY-deep {vld,id} shift register that tracks which requester owns each
// operand inside the shared unit; always shifts, never stalls.
module int16_pipe_tag_delay #(
  parameter int ID_W    = 2,
  parameter int LATENCY = 2
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            in_vld,
  input  logic [ID_W-1:0] in_id,
  output logic            out_vld,
  output logic [ID_W-1:0] out_id,
  output logic            busy
);

  logic [LATENCY-1:0]           vld_q, vld_d;
  logic [LATENCY-1:0][ID_W-1:0] id_q, id_d;

  always_comb begin
    vld_d    = '0;
    id_d     = '0;
    vld_d[0] = in_vld;
    id_d[0]  = in_id;
    for (int i = 1; i < LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
      id_d[i]  = id_q[i-1];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld_q <= '0;
      id_q  <= '0;
    end else begin
      vld_q <= vld_d;
      id_q  <= id_d;
    end
  end

  assign out_vld = vld_q[LATENCY-1];
  assign out_id  = id_q[LATENCY-1];
  assign busy    = |vld_q;

endmodule

// File: rtl/int16_pipe_share_arbiter.sv
// Round-robin sharing of one fixed-latency INT16 unit between N_REQ requesters,
// with tag-based result routing and a drain FSM for quiescing the unit.
module int16_pipe_share_arbiter
  import int16_pipe_share_arbiter_pkg::*;
#(
  parameter int N_REQ   = N_REQ_DEF,
  parameter int WIDTH   = WIDTH_DEF,
  parameter int LATENCY = LATENCY_DEF
) (
  input logic                        clock,
  input logic                        reset,
  int16_pipe_share_arbiter_if.slave  bus
);

  localparam int IDW = $clog2(N_REQ);

  state_e           state_q, state_d;
  logic             drain_done_q, drain_done_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]   grant;
  logic             issue;
  logic [N_REQ-1:0] ready;
  logic [WIDTH-1:0] unit_in;
  logic             tag_vld;
  logic [IDW-1:0]   tag_id;
  logic             busy;

  // Reverse scan so the candidate closest to rr_ptr wins; reset gates grants
  // so nothing is offered to requesters while the block is held in reset.
  always_comb begin
    issue = 1'b0;
    grant = '0;
    if (state_q == ST_RUN && !bus.drain_req && !reset) begin
      for (int k = N_REQ - 1; k >= 0; k--) begin
        if (bus.req_valid[(int'(rr_ptr_q) + k) % N_REQ]) begin
          issue = 1'b1;
          grant = IDW'((int'(rr_ptr_q) + k) % N_REQ);
        end
      end
    end
  end

  always_comb begin
    ready    = '0;
    unit_in  = '0;
    rr_ptr_d = rr_ptr_q;
    if (issue) begin
      ready    = N_REQ'(1) << grant;
      unit_in  = bus.req_data[int'(grant)*WIDTH +: WIDTH];
      rr_ptr_d = (int'(grant) == N_REQ - 1) ? '0 : grant + IDW'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (bus.drain_req) state_d = busy ? ST_DRAIN : ST_DONE;
      ST_DRAIN: if (!busy) state_d = ST_DONE;
      ST_DONE:  if (!bus.drain_req) state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
    drain_done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_RUN;
      drain_done_q <= 1'b0;
      rr_ptr_q     <= '0;
    end else begin
      state_q      <= state_d;
      drain_done_q <= drain_done_d;
      rr_ptr_q     <= rr_ptr_d;
    end
  end

  int16_pipe_tag_delay #(
    .ID_W    (IDW),
    .LATENCY (LATENCY)
  ) u_tag_delay (
    .clock   (clock),
    .reset   (reset),
    .in_vld  (issue),
    .in_id   (grant),
    .out_vld (tag_vld),
    .out_id  (tag_id),
    .busy    (busy)
  );

  assign bus.req_ready  = ready;
  assign bus.unit_in    = unit_in;
  assign bus.rsp_valid  = tag_vld ? (N_REQ'(1) << tag_id) : '0;
  assign bus.rsp_data   = tag_vld ? bus.unit_out : '0;
  assign bus.drain_done = drain_done_q;
  assign bus.busy       = busy;
  assign bus.state_dbg  = state_q;

endmodule

// File: tb/tb_int16_pipe_share_arbiter.sv
// Directed bench for the shared-pipeline arbiter with a response scoreboard.
module tb_int16_pipe_share_arbiter;
  import int16_pipe_share_arbiter_pkg::*;

  localparam int N   = 4;
  localparam int W   = 16;
  localparam int LAT = 2;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  int16_pipe_share_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus ();

  int16_pipe_share_arbiter #(
    .N_REQ   (N),
    .WIDTH   (W),
    .LATENCY (LAT)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Shared unit model: two-register chain, no reset, no enable.
  logic [W-1:0] u1, u2;
  always_ff @(posedge clock) begin
    u1 <= bus.unit_in;
    u2 <= u1;
  end
  assign bus.unit_out = u2;

  logic [N+W-1:0] exp_q[$];
  logic [N+W-1:0] mon_e;
  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every presented response is popped and compared.
  always @(negedge clock) begin
    if (bus.rsp_valid != '0) begin
      if (exp_q.size() == 0) begin
        vec_cnt++;
        err_cnt++;
        $display("FAIL unexpected_rsp: got valid=%b data=%h expected none (t=%0t)",
                 bus.rsp_valid, bus.rsp_data, $time);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rsp", 32'({bus.rsp_valid, bus.rsp_data}), 32'(mon_e));
      end
    end
  end

  function automatic logic [N*W-1:0] pk(input logic [W-1:0] a0, a1, a2, a3);
    return {a3, a2, a1, a0};
  endfunction

  // exp_busy / exp_done: 0 or 1 to check, 2 to skip.
  task automatic step(input logic [N-1:0] v, input logic [N*W-1:0] d, input logic drn,
                      input logic [N-1:0] exp_rdy, input int exp_busy, input int exp_done,
                      input bit push);
    logic [W-1:0] exp_in;
    bus.req_valid = v;
    bus.req_data  = d;
    bus.drain_req = drn;
    exp_in = '0;
    for (int i = 0; i < N; i++) if (exp_rdy[i]) exp_in = d[i*W +: W];
    @(negedge clock);
    chk("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
    chk("unit_in", 32'(bus.unit_in), 32'(exp_in));
    if (exp_busy != 2) chk("busy", 32'(bus.busy), 32'(exp_busy));
    if (exp_done != 2) chk("drain_done", 32'(bus.drain_done), 32'(exp_done));
    if (push && exp_rdy != '0) exp_q.push_back({exp_rdy, exp_in});
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset(input logic [N-1:0] v, input logic [N*W-1:0] d, input bit check);
    reset         = 1'b1;
    bus.req_valid = v;
    bus.req_data  = d;
    bus.drain_req = 1'b0;
    @(negedge clock);
    if (check) begin
      chk("rst_req_ready", 32'(bus.req_ready), 32'h0);
      chk("rst_unit_in", 32'(bus.unit_in), 32'h0);
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
      chk("rst_rsp_data", 32'(bus.rsp_data), 32'h0);
      chk("rst_drain_done", 32'(bus.drain_done), 32'h0);
      chk("rst_busy", 32'(bus.busy), 32'h0);
      chk("rst_state", 32'(bus.state_dbg), 32'(ST_RUN));
    end
    @(posedge clock);
    #1;
    reset         = 1'b0;
    bus.req_valid = '0;
    bus.req_data  = '0;
  endtask

  initial begin
    reset         = 1'b1;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.drain_req = 1'b0;
    apply_reset('0, '0, 1'b1);

    // Single request from requester 1; busy high for exactly two cycles.
    step(4'b0010, pk(16'h0, 16'h1234, 16'h0, 16'h0), 1'b0, 4'b0010, 0, 0, 1'b1);
    step(4'b0000, '0, 1'b0, 4'b0000, 1, 0, 1'b0);
    step(4'b0000, '0, 1'b0, 4'b0000, 1, 0, 1'b0);
    step(4'b0000, '0, 1'b0, 4'b0000, 0, 0, 1'b0);

    // All four valid: strict rotation 0,1,2,3,0.
    apply_reset('0, '0, 1'b0);
    step(4'b1111, pk(16'h00A0, 16'h00A1, 16'h00A2, 16'h00A3), 1'b0, 4'b0001, 0, 2, 1'b1);
    step(4'b1111, pk(16'h00A0, 16'h00A1, 16'h00A2, 16'h00A3), 1'b0, 4'b0010, 1, 2, 1'b1);
    step(4'b1111, pk(16'h00A0, 16'h00A1, 16'h00A2, 16'h00A3), 1'b0, 4'b0100, 1, 2, 1'b1);
    step(4'b1111, pk(16'h00A0, 16'h00A1, 16'h00A2, 16'h00A3), 1'b0, 4'b1000, 1, 2, 1'b1);
    step(4'b1111, pk(16'h00A0, 16'h00A1, 16'h00A2, 16'h00A3), 1'b0, 4'b0001, 1, 2, 1'b1);

    // Grant 2 leaves rr_ptr=3; 4'b1001 then grants 3 and wraps to 0.
    step(4'b0100, pk(16'h0, 16'h0, 16'h00C2, 16'h0), 1'b0, 4'b0100, 1, 2, 1'b1);
    step(4'b1001, pk(16'h00C0, 16'h0, 16'h0, 16'h00C3), 1'b0, 4'b1000, 1, 2, 1'b1);
    step(4'b1001, pk(16'h00C0, 16'h0, 16'h0, 16'h00C3), 1'b0, 4'b0001, 1, 2, 1'b1);
    step(4'b0000, '0, 1'b0, 4'b0000, 1, 0, 1'b0);
    step(4'b0000, '0, 1'b0, 4'b0000, 1, 0, 1'b0);
    step(4'b0000, '0, 1'b0, 4'b0000, 0, 0, 1'b0);

    // Drain with one operand in flight, then resume.
    apply_reset('0, '0, 1'b0);
    step(4'b0001, pk(16'h0D00, 16'h0, 16'h0, 16'h0), 1'b0, 4'b0001, 0, 0, 1'b1);
    step(4'b0001, pk(16'h0D01, 16'h0, 16'h0, 16'h0), 1'b1, 4'b0000, 1, 0, 1'b0);
    step(4'b0001, pk(16'h0D01, 16'h0, 16'h0, 16'h0), 1'b1, 4'b0000, 1, 0, 1'b0);
    step(4'b0001, pk(16'h0D01, 16'h0, 16'h0, 16'h0), 1'b1, 4'b0000, 0, 0, 1'b0);
    step(4'b0001, pk(16'h0D01, 16'h0, 16'h0, 16'h0), 1'b1, 4'b0000, 0, 1, 1'b0);
    step(4'b0001, pk(16'h0D01, 16'h0, 16'h0, 16'h0), 1'b0, 4'b0000, 0, 1, 1'b0);
    step(4'b0001, pk(16'h0D02, 16'h0, 16'h0, 16'h0), 1'b0, 4'b0001, 0, 0, 1'b1);
    step(4'b0000, '0, 1'b0, 4'b0000, 1, 0, 1'b0);
    step(4'b0000, '0, 1'b0, 4'b0000, 1, 0, 1'b0);
    step(4'b0000, '0, 1'b0, 4'b0000, 0, 0, 1'b0);

    // Reset with two operands in flight: both results must be dropped.
    apply_reset('0, '0, 1'b0);
    step(4'b0100, pk(16'h0, 16'h0, 16'h00E0, 16'h0), 1'b0, 4'b0100, 0, 0, 1'b0);
    step(4'b1000, pk(16'h0, 16'h0, 16'h0, 16'h00E1), 1'b0, 4'b1000, 1, 0, 1'b0);
    apply_reset(4'b1111, pk(16'h00E2, 16'h00E2, 16'h00E2, 16'h00E2), 1'b1);
    step(4'b0100, pk(16'h0, 16'h0, 16'h00E2, 16'h0), 1'b0, 4'b0100, 0, 0, 1'b1);
    step(4'b0000, '0, 1'b0, 4'b0000, 1, 0, 1'b0);
    step(4'b0000, '0, 1'b0, 4'b0000, 1, 0, 1'b0);
    step(4'b0000, '0, 1'b0, 4'b0000, 0, 0, 1'b0);

    // Drain while idle: DONE on the next edge, no grants while draining.
    apply_reset('0, '0, 1'b0);
    step(4'b1111, pk(16'h00F0, 16'h00F1, 16'h00F2, 16'h00F3), 1'b1, 4'b0000, 0, 0, 1'b0);
    step(4'b1111, pk(16'h00F0, 16'h00F1, 16'h00F2, 16'h00F3), 1'b1, 4'b0000, 0, 1, 1'b0);
    step(4'b1111, pk(16'h00F0, 16'h00F1, 16'h00F2, 16'h00F3), 1'b1, 4'b0000, 0, 1, 1'b0);
    step(4'b1111, pk(16'h00F0, 16'h00F1, 16'h00F2, 16'h00F3), 1'b0, 4'b0000, 0, 1, 1'b0);
    step(4'b1111, pk(16'h00F0, 16'h00F1, 16'h00F2, 16'h00F3), 1'b0, 4'b0001, 0, 0, 1'b1);
    step(4'b0000, '0, 1'b0, 4'b0000, 1, 0, 1'b0);
    step(4'b0000, '0, 1'b0, 4'b0000, 1, 0, 1'b0);
    step(4'b0000, '0, 1'b0, 4'b0000, 0, 0, 1'b0);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clock);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
